// File: rtl/fp_result_pack_round_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_result_pack_round_if
// Description : Handshake bundle for the FP32 result pack/round stage.
//               slave  = the pack/round block, master = the producer/consumer
//               side that drives the extended result and takes the packed word.
// Revision    : 1.0  initial release
// ============================================================================
interface fp_result_pack_round_if;
    logic        in_valid;
    logic        in_ready;
    logic [36:0] in_num;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp;

    modport slave (
        input  in_valid, in_num, out_ready,
        output in_ready, out_valid, out_fp
    );

    modport master (
        output in_valid, in_num, out_ready,
        input  in_ready, out_valid, out_fp
    );
endinterface
`default_nettype wire

// File: rtl/fp_result_pack_round.sv
`default_nettype none
// ============================================================================
// Module      : fp_result_pack_round
// Description : Renormalises the 37-bit extended FP32 adder result (iterative
//               left shift or single right shift), rounds to nearest-even and
//               packs an IEEE-754 single. Overflow forces infinity, an
//               all-zero mantissa gives signed zero, exponent floor 1 gives a
//               denormal. Optional macro FP_PACK_FLAGS_EN adds registered
//               inexact/overflow/underflow flag outputs.
// Revision    : 1.0  initial release
// ============================================================================
module fp_result_pack_round #(
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  wire                   clk,
    input  wire                   rst_n,
    fp_result_pack_round_if.slave bus
`ifdef FP_PACK_FLAGS_EN
    ,
    output logic                  flag_inexact,
    output logic                  flag_overflow,
    output logic                  flag_underflow
`endif
);

    // Clamp to the legal 1..4 range so the leading-zero counter stays 3 bits.
    localparam int c_SPC = (SHIFT_PER_CYCLE < 1) ? 1 :
                           (SHIFT_PER_CYCLE > 4) ? 4 : SHIFT_PER_CYCLE;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_NORM  = 2'd1;
    localparam logic [1:0] c_ST_ROUND = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]  r_state, w_state_nxt;
    logic        r_sign,  w_sign_nxt;
    logic [8:0]  r_exp,   w_exp_nxt;     // 9 bits: no wrap past 255
    logic [27:0] r_man,   w_man_nxt;
    logic [31:0] r_out_fp, w_out_fp_nxt;
`ifdef FP_PACK_FLAGS_EN
    logic        r_inexact,   w_inexact_nxt;
    logic        r_overflow,  w_overflow_nxt;
    logic        r_underflow, w_underflow_nxt;
`endif

    logic [2:0]  w_lz;
    logic        w_lz_stop;
    logic [8:0]  w_exp_room;
    logic [2:0]  w_shamt;
    logic        w_round_up;
    logic [24:0] w_sum;
    logic [23:0] w_rnd_man;
    logic [8:0]  w_rnd_exp;
    logic        w_ovf;
    logic        w_inexact;
    logic [7:0]  w_pack_exp;
    logic        w_underflow;

    // Leading zeros from bit 26 downward, counted only up to the per-cycle cap.
    always_comb begin
        w_lz      = 3'd0;
        w_lz_stop = 1'b0;
        for (int i = 0; i < c_SPC; i++) begin
            if (!w_lz_stop) begin
                if (!r_man[26-i]) begin
                    w_lz = w_lz + 3'd1;
                end else begin
                    w_lz_stop = 1'b1;
                end
            end
        end
    end

    // Shift amount limited so the exponent never drops below 1, plus the
    // nearest-even rounding datapath used in ROUND.
    always_comb begin
        w_exp_room  = r_exp - 9'd1;
        w_shamt     = ({6'd0, w_lz} < w_exp_room) ? w_lz : w_exp_room[2:0];
        w_round_up  = r_man[2] & (r_man[1] | r_man[0] | r_man[3]);
        w_sum       = {1'b0, r_man[26:3]} + {24'd0, w_round_up};
        w_rnd_man   = w_sum[24] ? w_sum[24:1] : w_sum[23:0];
        w_rnd_exp   = r_exp + {8'd0, w_sum[24]};
        w_ovf       = (w_rnd_exp >= 9'd255);
        w_inexact   = (|r_man[2:0]) | w_ovf;
        // A denormal that rounds up into bit 26 naturally keeps exponent 1.
        w_pack_exp  = w_rnd_man[23] ? w_rnd_exp[7:0] : 8'd0;
        w_underflow = !w_ovf && (w_pack_exp == 8'd0) && w_inexact;
    end

    // Next-state and datapath update for IDLE/NORM/ROUND/DONE.
    always_comb begin
        w_state_nxt  = r_state;
        w_sign_nxt   = r_sign;
        w_exp_nxt    = r_exp;
        w_man_nxt    = r_man;
        w_out_fp_nxt = r_out_fp;
`ifdef FP_PACK_FLAGS_EN
        w_inexact_nxt   = r_inexact;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (bus.in_valid) begin
                    w_sign_nxt  = bus.in_num[36];
                    // Exponent 0 is the denormal encoding; treat it as 1.
                    w_exp_nxt   = (bus.in_num[35:28] == 8'd0) ? 9'd1 : {1'b0, bus.in_num[35:28]};
                    w_man_nxt   = bus.in_num[27:0];
                    w_state_nxt = c_ST_NORM;
                end
            end
            c_ST_NORM: begin
                if (r_man[27]) begin
                    // Carry out: the dropped bit folds into sticky.
                    w_man_nxt   = {1'b0, r_man[27:2], r_man[1] | r_man[0]};
                    w_exp_nxt   = r_exp + 9'd1;
                    w_state_nxt = c_ST_ROUND;
                end else if (r_man == 28'd0) begin
                    w_out_fp_nxt = {r_sign, 31'd0};
                    w_state_nxt  = c_ST_DONE;
                end else if (r_man[26] || (r_exp == 9'd1)) begin
                    w_state_nxt = c_ST_ROUND;
                end else begin
                    w_man_nxt = r_man << w_shamt;
                    w_exp_nxt = r_exp - {6'd0, w_shamt};
                end
            end
            c_ST_ROUND: begin
                if (w_ovf) begin
                    w_out_fp_nxt = {r_sign, 8'hFF, 23'd0};
                end else begin
                    w_out_fp_nxt = {r_sign, w_pack_exp, w_rnd_man[22:0]};
                end
`ifdef FP_PACK_FLAGS_EN
                w_inexact_nxt   = w_inexact;
                w_overflow_nxt  = w_ovf;
                w_underflow_nxt = w_underflow;
`endif
                w_state_nxt = c_ST_DONE;
            end
            default: begin
                if (bus.out_ready) begin
`ifdef FP_PACK_FLAGS_EN
                    w_inexact_nxt   = 1'b0;
                    w_overflow_nxt  = 1'b0;
                    w_underflow_nxt = 1'b0;
`endif
                    w_state_nxt = c_ST_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_sign   <= 1'b0;
            r_exp    <= 9'd0;
            r_man    <= 28'd0;
            r_out_fp <= 32'd0;
`ifdef FP_PACK_FLAGS_EN
            r_inexact   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_sign   <= w_sign_nxt;
            r_exp    <= w_exp_nxt;
            r_man    <= w_man_nxt;
            r_out_fp <= w_out_fp_nxt;
`ifdef FP_PACK_FLAGS_EN
            r_inexact   <= w_inexact_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
`endif
        end
    end

    assign bus.in_ready  = (r_state == c_ST_IDLE);
    assign bus.out_valid = (r_state == c_ST_DONE);
    assign bus.out_fp    = r_out_fp;
`ifdef FP_PACK_FLAGS_EN
    assign flag_inexact   = r_inexact;
    assign flag_overflow  = r_overflow;
    assign flag_underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_result_pack_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_result_pack_round
// Description : Self-checking bench for fp_result_pack_round: directed plan
//               vectors, handshake hold, mid-shift reset and random vectors
//               against an arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fp_result_pack_round;

    localparam int SPC = 1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    fp_result_pack_round_if bus ();

`ifdef FP_PACK_FLAGS_EN
    logic flag_inexact, flag_overflow, flag_underflow;
`endif

    fp_result_pack_round #(.SHIFT_PER_CYCLE(SPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave)
`ifdef FP_PACK_FLAGS_EN
        ,
        .flag_inexact   (flag_inexact),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Value-level model: integer mantissa, total shift computed at once,
    // nearest-even from the 3-bit remainder.
    function automatic void ref_model(input logic [36:0] num, output logic [31:0] fp,
                                      output int lat, output logic [2:0] flg);
        longint m, v, rem;
        int     e, k, lz, pexp;
        logic   ovf, inx, unf;
        m = longint'(num[27:0]);
        e = int'(num[35:28]);
        k = 0;
        if (e == 0) e = 1;
        if (m == 0) begin
            fp  = {num[36], 31'd0};
            lat = 2;
            flg = 3'b000;
            return;
        end
        if (m >= (longint'(1) << 27)) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
        end else if (e > 1) begin
            lz = 0;
            while ((m << lz) < (longint'(1) << 26)) lz++;
            k = (lz < e - 1) ? lz : e - 1;
            m = m << k;
            e = e - k;
        end
        lat = 3 + (k + SPC - 1) / SPC;
        v   = m >> 3;
        rem = m & 7;
        if (rem > 4 || (rem == 4 && (v & 1) == 1)) v = v + 1;
        if (v == (longint'(1) << 24)) begin
            v = v >> 1;
            e = e + 1;
        end
        ovf  = (e >= 255);
        inx  = (rem != 0) || ovf;
        pexp = (v >= (longint'(1) << 23)) ? e : 0;
        unf  = !ovf && (pexp == 0) && inx;
        if (ovf) fp = {num[36], 8'hFF, 23'd0};
        else     fp = {num[36], 8'(pexp), 23'(v)};
        flg = {ovf, inx, unf};
    endfunction

    // One transaction: accept, measure latency, hold in DONE, then drain.
    task automatic run_vector(input logic [36:0] num, input int hold, output logic [31:0] got);
        logic [31:0] efp;
        int          elat;
        int          edges;
        logic [2:0]  eflg;
        ref_model(num, efp, elat, eflg);
        @(negedge clk);
        for (int t = 0; t < 50 && !bus.in_ready; t++) @(negedge clk);
        check_value("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_num   = num;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_value("latency", edges, elat);
        check_value("out_fp", bus.out_fp, efp);
        got = bus.out_fp;
`ifdef FP_PACK_FLAGS_EN
        check_value("flags", {flag_overflow, flag_inexact, flag_underflow}, eflg);
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_value("hold_state", {bus.out_valid, bus.in_ready, bus.out_fp}, {2'b10, efp});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_value("drain", {bus.out_valid, bus.in_ready}, 2'b01);
`ifdef FP_PACK_FLAGS_EN
        check_value("flags_clr", {flag_overflow, flag_inexact, flag_underflow}, 3'b000);
`endif
    endtask

    logic [36:0] plan_in  [7];
    logic [31:0] plan_out [7];

    initial begin
        logic [31:0] got;
        logic [36:0] num;
        int          sel;

        plan_in[0] = {1'b0, 8'd127, 28'h8000000}; plan_out[0] = 32'h40000000;
        plan_in[1] = {1'b0, 8'd130, 28'h0100000}; plan_out[1] = 32'h3E000000;
        plan_in[2] = {1'b0, 8'd127, 28'h400000C}; plan_out[2] = 32'h3F800002;
        plan_in[3] = {1'b0, 8'd127, 28'h4000004}; plan_out[3] = 32'h3F800000;
        plan_in[4] = {1'b0, 8'd254, 28'h8000000}; plan_out[4] = 32'h7F800000;
        plan_in[5] = {1'b0, 8'd1,   28'h0000008}; plan_out[5] = 32'h00000001;
        plan_in[6] = {1'b1, 8'd90,  28'h0000000}; plan_out[6] = 32'h80000000;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_num    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_value("rst_state", {bus.in_ready, bus.out_valid, bus.out_fp}, {2'b10, 32'd0});
        rst_n = 1'b1;

        // Plan vectors; the carry case also sits 5 cycles in DONE.
        for (int i = 0; i < 7; i++) begin
            run_vector(plan_in[i], (i == 0) ? 5 : 0, got);
            check_value("plan_out", got, plan_out[i]);
        end

        // Reset in the middle of a 26-step left normalise.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_num   = {1'b0, 8'd200, 28'h0000001};
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_value("busy_in_norm", {bus.in_ready, bus.out_valid}, 2'b00);
        rst_n = 1'b0;
        #1;
        check_value("async_rst", {bus.in_ready, bus.out_valid, bus.out_fp}, {2'b10, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        run_vector({1'b1, 8'd127, 28'h8000000}, 1, got);
        check_value("post_rst_out", got, 32'hC0000000);

        // Random vectors spread over small, large and generic exponents.
        for (int r = 0; r < 150; r++) begin
            sel = int'($urandom_range(0, 3));
            num[36] = 1'($urandom);
            if (sel == 0)      num[35:28] = 8'($urandom_range(0, 8));
            else if (sel == 1) num[35:28] = 8'($urandom_range(245, 255));
            else               num[35:28] = 8'($urandom);
            num[27:0] = 28'($urandom) >> $urandom_range(0, 28);
            run_vector(num, int'($urandom_range(0, 3)), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_result_pack_round.md
Name: fp_result_pack_round

Overview:
- Output-side counterpart of the operand unpack/normalise stage in the FP32 adder.
- Takes the 37-bit extended adder result and produces a packed IEEE-754 single word:
  - renormalises left (iteratively) or right,
  - rounds to nearest-even,
  - detects overflow, denormal and zero.
- Sits between the mantissa adder and the adder's result register, with valid/ready handshake on both sides.

Parameters:
SHIFT_PER_CYCLE, 1, maximum left-shift positions applied per NORM cycle; legal values 1 to 4.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  extended result present
in_ready  output  1  block can accept (high only in IDLE)
in_num  input  37  [36] sign, [35:28] biased exponent, [27:0] mantissa: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky
out_valid  output  1  packed result valid
out_ready  input  1  consumer accepts result
out_fp  output  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Asserting rst_n low gives state IDLE, in_ready=1, out_valid=0, out_fp=0, flags=0, internal registers=0. Valid mid-operation; any in-flight result is discarded.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - On in_valid&&in_ready, latch sign, exp and mantissa; go to NORM.
  - An input exponent of 0 is held internally as 1 and marked denormal-capable.
- NORM (one decision per cycle, checked in this priority order):
  - M[27]=1: shift right 1, OR the shifted-out bit into sticky, exp+1; go to ROUND.
  - M==0: result is signed zero {sign,31'b0}; go to DONE.
  - M[26]=1: go to ROUND.
  - exp==1: denormal; hold M; go to ROUND.
  - Otherwise: shift left by n = min(SHIFT_PER_CYCLE, leading zeros above bit26, exp-1); exp-=n; stay in NORM.
- ROUND:
  - round_up = G & (R | S | M[3]). Add round_up to M[26:3].
  - If the 24-bit sum carries out, shift right 1 and exp+1.
  - If exp>=255 after this, result is {sign,8'hFF,23'b0}.
  - Otherwise packed exp = M[26] ? exp : 0 (denormal rounding into bit26 yields exp 1); frac = M[25:3].
  - Go to DONE.
- DONE:
  - out_valid=1; out_fp and flags are stable.
  - On out_ready, go to IDLE the next cycle with out_valid=0.
  - in_ready stays low until IDLE, so a new input is never accepted in the same cycle a result leaves.
- Latency from the accept edge to out_valid: 3 + ceil(k/SHIFT_PER_CYCLE) cycles, where k is the number of left shifts. A no-shift case takes 3 cycles.
- Throughput: one result per latency+1 cycles minimum.
- Exponent arithmetic uses a 9-bit internal register, so no wrap at 255.
- Inputs with exp=255 are not NaN/Inf-propagated; they are treated as overflow.

Optional Feature:
- Macro FP_PACK_FLAGS_EN.
- Defined: adds output ports flag_inexact, flag_overflow, flag_underflow, each 1 bit, all registered and valid with out_valid.
  - flag_inexact: G|R|S nonzero at ROUND, or overflow occurred.
  - flag_overflow: result forced to infinity.
  - flag_underflow: packed exp=0 and inexact.
  - All flags clear on reset and on leaving DONE.
- Undefined: the ports do not exist; datapath and timing are identical.

Test Plan:
- Carry normalise, 1.0+1.0: in_num={0,8'd127,28'h8000000} -> out_fp=32'h40000000; out_valid exactly 3 cycles after accept.
- Left normalise: in_num={0,8'd130,28'h0100000}, SHIFT_PER_CYCLE=1 -> 6 NORM shift cycles; out_fp=32'h3E000000.
- Round-to-nearest-even:
  - {0,127,28'h400000C} -> 32'h3F800002 (tie, odd LSB, round up).
  - {0,127,28'h4000004} -> 32'h3F800000 (tie, even, no round); flag_inexact=1.
- Overflow: {0,8'd254,28'h8000000} -> 32'h7F800000, flag_overflow=1.
  - Denormal {0,8'd1,28'h0000008} -> 32'h00000001.
  - Zero {1,8'd90,28'h0} -> 32'h80000000.
- Handshake and reset:
  - Hold out_ready low 5 cycles in DONE -> out_valid and out_fp stay constant; in_ready=0 throughout.
  - Drop rst_n during NORM of a long shift -> out_valid=0 and in_ready=1 immediately; the next input completes normally.
